// File: rtl/matrixops_gen.sv
// Serial-entry N x N matrix relation checker: loads A/B one element pair per enter, then reports a verdict on Z.
// Optional MATRIXOPS_EARLY_EXIT_EN ends element-compare modes at the first mismatch.
module matrixops_gen #(
  parameter int N = 2,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enter,
  input  logic [1:0]   mode,
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  output logic         Z,
  output logic         done,
  output logic         busy
);
  localparam int NN = N * N;
  localparam int AW = $clog2(NN);
  localparam int IW = $clog2(N);
  localparam int TW = W + $clog2(N);

  typedef enum logic [1:0] {IDLE, LOAD, EVAL} state_t;
  state_t state, state_nx;

  logic [NN-1:0][W-1:0] ma, mb;
  logic [AW-1:0]        k, e, et;
  logic [IW-1:0]        li, lj, ei, ej;
  logic [TW-1:0]        tra, trb;
  logic [1:0]           md;
  logic                 r, elem_ok, last_k, last_e, eval_end;

  // et is the linear index of the transposed position of element e
  assign et     = AW'(ej * N + ei);
  assign last_k = (k == AW'(NN - 1));
  assign last_e = (e == AW'(NN - 1));
  assign busy   = (state != IDLE);

  always_comb begin
    elem_ok = 1'b1;
    case (md)
      2'd1:    elem_ok = (ma[e] == mb[et]);
      2'd3:    elem_ok = (ma[e] == ma[et]);
      default: elem_ok = (ma[e] == mb[e]);
    endcase
  end

`ifdef MATRIXOPS_EARLY_EXIT_EN
  assign eval_end = (md == 2'd2) || last_e || !elem_ok;
`else
  assign eval_end = (md == 2'd2) || last_e;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enter) state_nx = LOAD;
      LOAD:    if (enter && last_k) state_nx = EVAL;
      EVAL:    if (eval_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k    <= '0;
      e    <= '0;
      ei   <= '0;
      ej   <= '0;
      li   <= '0;
      lj   <= '0;
      tra  <= '0;
      trb  <= '0;
      md   <= '0;
      r    <= 1'b1;
      Z    <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (enter) begin
          ma[0] <= X;
          mb[0] <= Y;
          md    <= mode;
          Z     <= 1'b0;
          k     <= AW'(1);
          li    <= '0;
          lj    <= IW'(1);
          tra   <= TW'(X);
          trb   <= TW'(Y);
        end
        LOAD: if (enter) begin
          ma[k] <= X;
          mb[k] <= Y;
          k     <= k + 1'b1;
          // li/lj track the row/column of k so the diagonal needs no divider
          if (li == lj) begin
            tra <= tra + TW'(X);
            trb <= trb + TW'(Y);
          end
          if (lj == IW'(N - 1)) begin
            lj <= '0;
            li <= li + 1'b1;
          end else begin
            lj <= lj + 1'b1;
          end
          if (last_k) begin
            e  <= '0;
            ei <= '0;
            ej <= '0;
            r  <= 1'b1;
          end
        end
        EVAL: begin
          r <= r & elem_ok;
          if (eval_end) begin
            Z    <= (md == 2'd2) ? (tra > trb) : (r & elem_ok);
            done <= 1'b1;
          end else begin
            e <= e + 1'b1;
            if (ej == IW'(N - 1)) begin
              ej <= '0;
              ei <= ei + 1'b1;
            end else begin
              ej <= ej + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
